// File: rtl/ble_cluster.sv
// ble_cluster: N scan-configured K-input LUT BLEs with an optional registered output per BLE.
// Define BLE_CLUSTER_CE_EN to add a ce port that gates the BLE flip-flops.
module ble_cluster #(
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           scan_en,
    input  logic           scan_in,
`ifdef BLE_CLUSTER_CE_EN
    input  logic           ce,
`endif
    input  logic [N*K-1:0] in,
    output logic           scan_out,
    output logic [N-1:0]   out,
    output logic           cfg_done,
    output logic           cfg_err
);
    localparam int T  = 2 ** K;
    localparam int L  = N * (T + 1);
    localparam int CW = $clog2(L + 2);
    localparam logic [CW-1:0] L_C   = CW'(L);
    localparam logic [CW-1:0] L_MAX = CW'(L + 1);

    typedef enum logic [1:0] {UNCONF, SHIFT, CONF, ERR} state_t;

    state_t          r_state;
    state_t          w_nxt;
    logic [L-1:0]    r_cfg;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_ff;
    logic [N-1:0]    w_lut;
    logic [N-1:0]    w_mode;
    logic [T-1:0]    w_tab [N];
    logic            w_ce;
    logic            w_conf;

`ifdef BLE_CLUSTER_CE_EN
    assign w_ce = ce;
`else
    assign w_ce = 1'b1;
`endif

    genvar b;
    for (b = 0; b < N; b++) begin : g_ble
        assign w_tab[b]  = r_cfg[b*(T+1) +: T];
        assign w_lut[b]  = w_tab[b][in[b*K +: K]];
        assign w_mode[b] = r_cfg[b*(T+1) + T];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= UNCONF;
        else     r_state <= w_nxt;
    end

    // A load is accepted only when exactly L bits were shifted.
    always_comb begin
        w_nxt = r_state;
        if (scan_en)
            w_nxt = SHIFT;
        else if (r_state == SHIFT)
            w_nxt = (r_cnt == L_C) ? CONF : ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg <= '0;
            r_cnt <= '0;
        end else if (scan_en) begin
            r_cfg <= {r_cfg[L-2:0], scan_in};
            r_cnt <= (r_state != SHIFT) ? CW'(1) : (r_cnt == L_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_ff <= '0;
        else if (!w_conf)     r_ff <= '0;
        else if (w_ce)        r_ff <= w_lut;
    end

    assign w_conf   = (r_state == CONF);
    assign out      = w_conf ? ((w_mode & w_lut) | (~w_mode & r_ff)) : '0;
    assign cfg_done = w_conf;
    assign cfg_err  = (r_state == ERR);
    assign scan_out = r_cfg[L-1];
endmodule

// File: tb/tb_ble_cluster.sv
// tb_ble_cluster: directed checks of ble_cluster with K=4, N=2 (L=34).
module tb_ble_cluster;
    localparam logic [33:0] CFG_A = {1'b0, 16'h6996, 1'b1, 16'h8000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       scan_in = 1'b0;
    logic [7:0] in_v = 8'h00;
    logic       scan_out;
    logic [1:0] out_v;
    logic       cfg_done;
    logic       cfg_err;
`ifdef BLE_CLUSTER_CE_EN
    logic       ce = 1'b1;
`endif
    int total = 0;
    int bad = 0;

    ble_cluster #(.K(4), .N(2)) dut (
        .clk(clk),
        .rst(rst),
        .scan_en(scan_en),
        .scan_in(scan_in),
`ifdef BLE_CLUSTER_CE_EN
        .ce(ce),
`endif
        .in(in_v),
        .scan_out(scan_out),
        .out(out_v),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Streams v[n-1] first; called just after a falling edge, returns after one.
    task automatic shift_bits(input logic [35:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            scan_en = 1'b1;
            scan_in = v[i];
            @(negedge clk);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic test_reset;
        scan_en = 1'b1;
        scan_in = 1'b1;
        #12;
        total++; if (scan_out !== 1'b0) begin bad++; $display("FAIL reset_scan_out got=%b exp=0", scan_out); end
        total++; if (out_v !== 2'b00) begin bad++; $display("FAIL reset_out got=%b exp=00", out_v); end
        total++; if ({cfg_done, cfg_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {cfg_done, cfg_err}); end
        scan_en = 1'b0;
        scan_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({cfg_done, cfg_err, scan_out} !== 3'b000) begin bad++; $display("FAIL post_reset_idle got=%b exp=000", {cfg_done, cfg_err, scan_out}); end
    endtask

    task automatic test_load;
        shift_bits(36'(CFG_A), 34);
        total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL load_done_early got=%b exp=0", cfg_done); end
        @(negedge clk);
        total++; if ({cfg_done, cfg_err} !== 2'b10) begin bad++; $display("FAIL load_flags got=%b exp=10", {cfg_done, cfg_err}); end
        in_v = 8'h0F;
        #1;
        total++; if (out_v !== 2'b01) begin bad++; $display("FAIL and4_comb got=%b exp=01", out_v); end
        @(negedge clk);
        total++; if (out_v !== 2'b01) begin bad++; $display("FAIL xor4_zero got=%b exp=01", out_v); end
        in_v = 8'h1F;
        #1;
        total++; if (out_v !== 2'b01) begin bad++; $display("FAIL xor4_latency got=%b exp=01", out_v); end
        @(negedge clk);
        total++; if (out_v !== 2'b11) begin bad++; $display("FAIL xor4_one got=%b exp=11", out_v); end
        in_v = 8'h3E;
        #1;
        total++; if (out_v !== 2'b10) begin bad++; $display("FAIL and4_drop got=%b exp=10", out_v); end
        @(negedge clk);
        total++; if (out_v !== 2'b00) begin bad++; $display("FAIL xor4_even got=%b exp=00", out_v); end
    endtask

    task automatic test_wrong_len;
        in_v = 8'h1F;
        shift_bits(36'h5_5555_5555, 33);
        @(negedge clk);
        total++; if ({cfg_done, cfg_err, out_v} !== 4'b0100) begin bad++; $display("FAIL short_load got=%b exp=0100", {cfg_done, cfg_err, out_v}); end
        shift_bits(36'hA_AAAA_AAAA, 35);
        @(negedge clk);
        total++; if ({cfg_done, cfg_err, out_v} !== 4'b0100) begin bad++; $display("FAIL long_load got=%b exp=0100", {cfg_done, cfg_err, out_v}); end
    endtask

    task automatic test_reset_mid;
        shift_bits('1, 34);
        @(negedge clk);
        in_v = 8'h00;
        #1;
        total++; if ({cfg_done, out_v} !== 3'b111) begin bad++; $display("FAIL ones_conf got=%b exp=111", {cfg_done, out_v}); end
        for (int i = 0; i < 10; i++) begin
            scan_en = 1'b1;
            @(negedge clk);
        end
        total++; if (scan_out !== 1'b1) begin bad++; $display("FAIL mid_scan_out got=%b exp=1", scan_out); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({out_v, cfg_done, cfg_err, scan_out} !== 5'b00000) begin bad++; $display("FAIL mid_reset got=%b exp=00000", {out_v, cfg_done, cfg_err, scan_out}); end
        scan_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({cfg_done, cfg_err} !== 2'b00) begin bad++; $display("FAIL reset_unconf got=%b exp=00", {cfg_done, cfg_err}); end
        shift_bits(36'(CFG_A), 34);
        @(negedge clk);
        in_v = 8'h0F;
        #1;
        total++; if ({cfg_done, out_v} !== 3'b101) begin bad++; $display("FAIL reload got=%b exp=101", {cfg_done, out_v}); end
    endtask

    task automatic test_scan_out;
        logic [33:0] seen;
        seen = '0;
        for (int i = 33; i >= 0; i--) begin
            scan_en = 1'b1;
            scan_in = 1'b0;
            #1;
            seen[i] = scan_out;
            @(negedge clk);
        end
        scan_en = 1'b0;
        total++; if (seen !== CFG_A) begin bad++; $display("FAIL scan_stream got=%h exp=%h", seen, CFG_A); end
        @(negedge clk);
        in_v = 8'h0F;
        #1;
        total++; if ({cfg_done, out_v} !== 3'b100) begin bad++; $display("FAIL zero_conf got=%b exp=100", {cfg_done, out_v}); end
        @(negedge clk);
        total++; if (out_v !== 2'b00) begin bad++; $display("FAIL zero_reg got=%b exp=00", out_v); end
    endtask

`ifdef BLE_CLUSTER_CE_EN
    task automatic test_ce;
        shift_bits(36'(CFG_A), 34);
        @(negedge clk);
        in_v = 8'h0F;
        @(negedge clk);
        ce = 1'b0;
        in_v = 8'h1F;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_v !== 2'b01) begin bad++; $display("FAIL ce_hold got=%b exp=01", out_v); end
        ce = 1'b1;
        #1;
        total++; if (out_v !== 2'b01) begin bad++; $display("FAIL ce_latency got=%b exp=01", out_v); end
        @(negedge clk);
        total++; if (out_v !== 2'b11) begin bad++; $display("FAIL ce_update got=%b exp=11", out_v); end
    endtask
`endif

    initial begin
        test_reset;
        test_load;
        test_wrong_len;
        test_reset_mid;
        test_scan_out;
`ifdef BLE_CLUSTER_CE_EN
        test_ce;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
